// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers plus a 3-column shift window,
// emitting one bordered window per input pixel with syncs delayed to match.
module matrix_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_img_vsync,
  input  logic              per_img_herf,
  input  logic              per_img_valid,
  input  logic [DATA_W-1:0] per_img_gray,
  output logic              post_img_vsync,
  output logic              post_img_herf,
  output logic              post_img_valid,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33
);
  localparam int CW     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe, vs_pipe, hs_pipe;
  logic [CW-1:0]   col_cnt, pix_col, s1_col, s2_col;
  logic [RW-1:0]   row_cnt, pix_row;
  logic            vs_rise, hs_fall, col_last, row_last;

  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];
  logic [DATA_W-1:0] s1_top, s1_mid, s1_bot;
  logic [2:0][2:0][DATA_W-1:0] win, mat;
  logic [2:0]        col_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      vs_pipe  <= '0;
      hs_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], per_img_valid};
      vs_pipe  <= {vs_pipe[STAGES-1:1],  per_img_vsync};
      hs_pipe  <= {hs_pipe[STAGES-1:1],  per_img_herf};
    end
  end

  // First stage of the sync chain doubles as the edge-detect history.
  assign vs_rise  = per_img_vsync & ~vs_pipe[1];
  assign hs_fall  = ~per_img_herf & hs_pipe[1];
  assign pix_col  = vs_rise ? '0 : col_cnt;
  assign pix_row  = vs_rise ? '0 : row_cnt;
  assign col_last = (pix_col == CW'(IMG_WIDTH - 1));
  assign row_last = (pix_row == RW'(IMG_HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (per_img_valid) begin
        col_cnt <= col_last ? '0 : pix_col + 1'b1;
        row_cnt <= (col_last && !row_last) ? pix_row + 1'b1 : pix_row;
      end else if (vs_rise) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end
      if (hs_fall) col_cnt <= '0;
    end
  end

  // Read-before-write: nonblocking updates see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (per_img_valid) begin
      lb2[pix_col] <= lb1[pix_col];
      lb1[pix_col] <= per_img_gray;
    end
  end

  // Row masking happens here; column masking at the output, since the
  // window's older columns may still hold the previous line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_top <= '0;
      s1_mid <= '0;
      s1_bot <= '0;
      s1_col <= '0;
    end else if (per_img_valid) begin
      s1_top <= (pix_row >= RW'(2)) ? lb2[pix_col] : '0;
      s1_mid <= (pix_row != '0)     ? lb1[pix_col] : '0;
      s1_bot <= per_img_gray;
      s1_col <= pix_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win    <= '0;
      s2_col <= '0;
    end else if (vld_pipe[1]) begin
      win[0] <= {s1_top, win[0][2:1]};
      win[1] <= {s1_mid, win[1][2:1]};
      win[2] <= {s1_bot, win[2][2:1]};
      s2_col <= s1_col;
    end
  end

  assign col_ok = {vld_pipe[2],
                   vld_pipe[2] && (s2_col != '0),
                   vld_pipe[2] && (s2_col >= CW'(2))};

  always_comb begin
    mat = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (col_ok[j]) mat[i][j] = win[i][j];
  end

  assign post_img_valid = vld_pipe[2];
  assign post_img_vsync = vs_pipe[2];
  assign post_img_herf  = hs_pipe[2];
  assign matrix_p11 = mat[0][0];
  assign matrix_p12 = mat[0][1];
  assign matrix_p13 = mat[0][2];
  assign matrix_p21 = mat[1][0];
  assign matrix_p22 = mat[1][1];
  assign matrix_p23 = mat[1][2];
  assign matrix_p31 = mat[2][0];
  assign matrix_p32 = mat[2][1];
  assign matrix_p33 = mat[2][2];
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen: image-array reference model checked every cycle,
// plus directed windows for first pixel, interior pixel and second frame.
module tb_matrix_3x3_gen;
  localparam int W = 8, H = 6, DW = 8;

  logic clk = 1'b0, rst_n;
  logic per_img_vsync, per_img_herf, per_img_valid;
  logic [DW-1:0] per_img_gray;
  logic post_img_vsync, post_img_herf, post_img_valid;
  logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
                 matrix_p23, matrix_p31, matrix_p32, matrix_p33;

  matrix_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(per_img_vsync), .per_img_herf(per_img_herf),
    .per_img_valid(per_img_valid), .per_img_gray(per_img_gray),
    .post_img_vsync(post_img_vsync), .post_img_herf(post_img_herf),
    .post_img_valid(post_img_valid),
    .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
    .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
    .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, vs, hs;
    logic [8:0][7:0] m;  // m[8] = p11 ... m[0] = p33
  } rec_t;

  rec_t prev;
  logic [7:0] img [H][W];
  int mr, mc;
  logic pvs, phs;
  int checks = 0, errors = 0;

  function automatic logic [74:0] obs();
    return {post_img_valid, post_img_vsync, post_img_herf,
            matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
            matrix_p23, matrix_p31, matrix_p32, matrix_p33};
  endfunction

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c + 1);
  endfunction

  task automatic chk(input string tag, input logic [74:0] o, input logic [74:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Drive one cycle, predict its output (seen one edge later), check previous.
  task automatic tick(input logic v, input logic vs, input logic hs, input logic [7:0] g);
    rec_t r;
    logic [74:0] o;
    int rr, cc;
    per_img_valid = v; per_img_vsync = vs; per_img_herf = hs; per_img_gray = g;
    r = '0; r.v = v; r.vs = vs; r.hs = hs;
    if (vs && !pvs) begin mr = 0; mc = 0; end
    if (v) begin
      img[mr][mc] = g;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          rr = mr - 2 + i; cc = mc - 2 + j;
          if (rr >= 0 && cc >= 0) r.m[8 - (i * 3 + j)] = img[rr][cc];
        end
      mc++;
      if (mc == W) begin mc = 0; if (mr < H - 1) mr++; end
    end
    if (!hs && phs) mc = 0;
    pvs = vs; phs = hs;
    @(posedge clk); #1;
    o = obs();
    chk("sync", {72'h0, o[74:72]}, {72'h0, prev.v, prev.vs, prev.hs});
    chk("window", {3'b0, o[71:0]}, {3'b0, prev.m});
    prev = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    per_img_valid = 0; per_img_vsync = 0; per_img_herf = 0; per_img_gray = '0;
    #1 chk("rst_async", obs(), '0);
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", obs(), '0);
    rst_n = 1'b1;
    prev = '0; mr = 0; mc = 0; pvs = 0; phs = 0;
  endtask

  initial begin
    logic [74:0] o;
    prev = '0; mr = 0; mc = 0; pvs = 0; phs = 0;
    do_reset();
    repeat (3) tick(0, 0, 0, 8'h00);

    // Frame A: formula pixels; row 2 with 3-cycle gaps.
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 0 && c == 0) begin
          tick(1, 1, 1, pix(0, 0));
          o = obs();
          chk("lat_t1", {72'h0, o[74:72]}, 75'h0);
          tick(0, 1, 1, 8'h00);
          o = obs();
          chk("lat_t2", {72'h0, o[74:72]}, 75'h7);
          chk("first_px", {3'b0, o[71:0]}, 75'h01);
        end else begin
          tick(1, 1, 1, pix(r, c));
          if (r == 2)
            for (int k = 0; k < 3; k++) begin
              tick(0, 1, 1, 8'h00);
              o = obs();
              if (c == 3 && k == 0)
                chk("interior_2_3", {3'b0, o[71:0]}, {3'b0, 72'h020304121314222324});
              if (c == 3 && k == 1)
                chk("gap_zero", o, {1'b0, 1'b1, 1'b1, 72'h0});
            end
        end
      end
      tick(0, 1, 0, 8'h00);
    end
    repeat (2) tick(0, 0, 0, 8'h00);

    // Frame B: stale frame-A rows must be masked.
    tick(0, 1, 0, 8'h00);
    tick(0, 1, 1, 8'h00);
    for (int c = 0; c < 6; c++) tick(1, 1, 1, pix(0, c));
    tick(0, 1, 1, 8'h00);
    o = obs();
    chk("frame2_0_5", {3'b0, o[71:0]}, {3'b0, 72'h000000000000040506});
    tick(1, 1, 1, pix(0, 6));
    tick(1, 1, 1, pix(0, 7));

    // Mid-stream reset with window data in flight.
    do_reset();
    repeat (4) tick(0, 0, 0, 8'h00);

    // Frame C: random pixels and random gaps.
    tick(0, 1, 0, 8'h00);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        tick(1, 1, 1, 8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) tick(0, 1, 1, 8'h00);
      end
      tick(0, 1, 0, 8'h00);
    end
    repeat (3) tick(0, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
